// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared types and encodings for the JK counter sequencer
package jk_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        DRV_HOLD = 2'd0,
        DRV_LOAD = 2'd1,
        DRV_STEP = 2'd2
    } drive_mode_e;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-high reset
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_counter_sequencer.sv
// rtl/jk_counter_sequencer.sv - LOAD/RUN/STOP controller driving a bank of JK cells as a counter
// Optional: JK_SEQ_AUTO_RELOAD_EN reloads the stored value at terminal and stays in RUN.
module jk_counter_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    drive_mode_e      mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] count_bar;

    assign cmd_ready = 1'b1;

    always_comb begin
        state_d  = state_q;
        term_d   = term_q;
        dir_d    = dir_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mode     = DRV_HOLD;
        load_val = cmd_data;

        case (state_q)
            ST_RUN: begin
                if (cmd_valid && (cmd_op == OP_LOAD || cmd_op == OP_RUN)) begin
                    err_d = 1'b1;
                end
                if (cmd_valid && cmd_op == OP_STOP) begin
                    state_d = ST_IDLE;
                end else if (count == term_q) begin
                    done_d = 1'b1;
`ifdef JK_SEQ_AUTO_RELOAD_EN
                    mode     = DRV_LOAD;
                    load_val = reload_q;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    mode = DRV_STEP;
                end
            end
            default: begin
                if (cmd_valid && cmd_op == OP_LOAD) begin
                    mode     = DRV_LOAD;
                    load_val = cmd_data;
                    reload_d = cmd_data;
                    state_d  = ST_IDLE;
                end else if (cmd_valid && cmd_op == OP_RUN) begin
                    term_d  = cmd_data;
                    dir_d   = cmd_dir;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        tgl    = '0;
        tgl[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tgl[i] = tgl[i-1] & ((dir_q == DIR_UP) ? count[i-1] : count_bar[i-1]);
        end
    end

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode)
            DRV_LOAD: begin
                cell_j = load_val;
                cell_k = ~load_val;
            end
            DRV_STEP: begin
                cell_j = tgl;
                cell_k = tgl;
            end
            default: begin
                cell_j = '0;
                cell_k = '0;
            end
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (cell_j[g]),
            .k     (cell_k[g]),
            .q     (count[g]),
            .q_bar (count_bar[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            term_q   <= '0;
            dir_q    <= DIR_UP;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            term_q   <= term_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb/tb_jk_counter_sequencer.sv - self-checking bench for jk_counter_sequencer
module tb_jk_counter_sequencer;

    localparam int W = 4;

    typedef struct {
        logic         valid;
        logic [1:0]   op;
        logic [W-1:0] data;
        logic         dir;
        logic [W-1:0] c;
        logic         b;
        logic         d;
        logic         e;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         b;
        logic         d;
        logic         e;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_dir = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         cmd_err;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    jk_counter_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] op, input int data, input logic dir,
                       input int c, input logic b, input logic d, input logic e);
        vec_t t;
        t.valid = v; t.op = op; t.data = W'(data); t.dir = dir;
        t.c = W'(c); t.b = b; t.d = d; t.e = e;
        vecs.push_back(t);
    endtask

    task automatic compare_front();
        exp_t x;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            check({x.tag, ".count"}, int'(count), int'(x.c));
            check({x.tag, ".busy"}, int'(busy), int'(x.b));
            check({x.tag, ".done"}, int'(done), int'(x.d));
            check({x.tag, ".cmd_err"}, int'(cmd_err), int'(x.e));
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t x;
        @(negedge clk);
        cmd_valid = v.valid;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_dir   = v.dir;
        x.c = v.c; x.b = v.b; x.d = v.d; x.e = v.e; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic run_vecs(input string prefix);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s[%0d]", prefix, i));
        end
        vecs.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", int'(count), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.cmd_err", int'(cmd_err), 0);
        check("reset.cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        reset = 1'b0;

`ifdef JK_SEQ_AUTO_RELOAD_EN
        add(1, 2'b01, 2, 1, 2, 0, 0, 0);
        add(1, 2'b10, 4, 1, 2, 1, 0, 0);
        add(0, 2'b00, 0, 0, 3, 1, 0, 0);
        add(0, 2'b00, 0, 0, 4, 1, 0, 0);
        add(0, 2'b00, 0, 0, 2, 1, 1, 0);
        add(0, 2'b00, 0, 0, 3, 1, 0, 0);
        add(0, 2'b00, 0, 0, 4, 1, 0, 0);
        add(0, 2'b00, 0, 0, 2, 1, 1, 0);
        add(1, 2'b11, 0, 0, 2, 0, 0, 0);
        add(0, 2'b00, 0, 0, 2, 0, 0, 0);
        run_vecs("reload");
`else
        // basic up-count 3 -> 7
        add(1, 2'b01, 3, 0, 3, 0, 0, 0);
        add(1, 2'b10, 7, 1, 3, 1, 0, 0);
        add(0, 2'b00, 0, 0, 4, 1, 0, 0);
        add(0, 2'b00, 0, 0, 5, 1, 0, 0);
        add(0, 2'b00, 0, 0, 6, 1, 0, 0);
        add(0, 2'b00, 0, 0, 7, 1, 0, 0);
        add(0, 2'b00, 0, 0, 7, 0, 1, 0);
        add(1, 2'b11, 0, 0, 7, 0, 0, 0);
        // up wrap 14 -> 1
        add(1, 2'b01, 14, 0, 14, 0, 0, 0);
        add(1, 2'b10, 1, 1, 14, 1, 0, 0);
        add(0, 2'b00, 0, 0, 15, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        // down wrap 2 -> 14
        add(1, 2'b01, 2, 0, 2, 0, 0, 0);
        add(1, 2'b10, 14, 0, 2, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 15, 1, 0, 0);
        add(0, 2'b00, 0, 0, 14, 1, 0, 0);
        add(0, 2'b00, 0, 0, 14, 0, 1, 0);
        run_vecs("tbl");

        // LOAD during RUN flags cmd_err but counting continues; STOP at 3 holds
        add(1, 2'b01, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 9, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1, 0, 0);
        add(1, 2'b01, 5, 0, 2, 1, 0, 1);
        add(0, 2'b00, 0, 0, 3, 1, 0, 0);
        add(1, 2'b11, 0, 0, 3, 0, 0, 0);
        add(0, 2'b00, 0, 0, 3, 0, 0, 0);
        // RUN during RUN must not replace terminal or direction
        add(1, 2'b10, 5, 1, 3, 1, 0, 0);
        add(1, 2'b10, 0, 0, 4, 1, 0, 1);
        add(0, 2'b00, 0, 0, 5, 1, 0, 0);
        add(0, 2'b00, 0, 0, 5, 0, 1, 0);
        run_vecs("err");

        // zero-length run: terminal equals start
        add(1, 2'b01, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 0, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0);
        run_vecs("zero");
`endif

        // asynchronous reset mid-run at count 5
        add(1, 2'b01, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 9, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 2, 1, 0, 0);
        add(0, 2'b00, 0, 0, 3, 1, 0, 0);
        add(0, 2'b00, 0, 0, 4, 1, 0, 0);
        add(0, 2'b00, 0, 0, 5, 1, 0, 0);
        run_vecs("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        check("async_rst.count", int'(count), 0);
        check("async_rst.busy", int'(busy), 0);
        check("async_rst.done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        add(0, 2'b00, 0, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0);
        run_vecs("post_rst");

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_counter_sequencer.md
Name: jk_counter_sequencer

Overview:
- Controller that sequences a bank of WIDTH JK flip-flop cells as a loadable, bidirectional, terminal-count counter.
- Accepts LOAD/RUN/STOP commands over a valid/ready interface.
- Drives the J/K inputs of every cell each cycle and reports busy/done status.
- Sits between a host command source and the flip-flop datapath; it replaces hand-wired counter chains.

Parameters:
- WIDTH, 4, number of JK cells (count bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid; tied high (every command is sampled).
- cmd_op  in  2  command: 00 NOP, 01 LOAD, 10 RUN, 11 STOP.
- cmd_data  in  WIDTH  LOAD: value to load; RUN: terminal value.
- cmd_dir  in  1  sampled with RUN: 1 up, 0 down.
- count  out  WIDTH  current Q of the JK cell bank.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching terminal.
- cmd_err  out  1  one-cycle pulse when LOAD or RUN is received while in RUN.

Behaviour:
- Reset: clk and reset are as stated under Ports. Effects:
  - All cells Q=0 (count=0); FSM=IDLE.
  - busy=0, done=0, cmd_err=0; stored terminal=0, dir=1, reload value=0.
  - Reset mid-run aborts immediately; no done pulse.
- Cell drive rules (controller outputs per bit i):
  - Hold: J=K=0.
  - Load: J=d[i], K=~d[i].
  - Count up: J=K=T[i], where T[0]=1 and T[i]=&count[i-1:0].
  - Count down: as up, but T[i]=&~count[i-1:0].
- Wrap-around is natural modulo 2^WIDTH: up from all-ones gives 0; down from 0 gives all-ones.
- A command is sampled at the edge where cmd_valid=1. Its effect is visible on count/state after that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE:
  - LOAD: count=cmd_data, reload value=cmd_data, next state IDLE.
  - RUN: latch terminal=cmd_data and dir=cmd_dir, next state RUN; count unchanged this edge.
  - STOP/NOP: no effect; DONE is retained until a command moves the FSM.
- RUN, evaluated each edge in priority order:
  1. STOP valid: hold count, next state IDLE, no done.
  2. count==terminal: hold count, next state DONE, done=1 for exactly the following cycle.
  3. Otherwise: step count by one in dir.
  - LOAD or RUN valid in RUN: command ignored, cmd_err=1 for one cycle, and the stepping rules above still apply.
- Latency:
  - First step occurs one edge after RUN is accepted.
  - RUN with terminal==count produces zero steps; DONE/done occur one edge after acceptance.
  - Steps needed = (terminal-start) mod 2^WIDTH for up; (start-terminal) mod 2^WIDTH for down.
- busy=1 exactly while state==RUN.
- done and cmd_err are registered outputs.

Optional Feature:
- JK_SEQ_AUTO_RELOAD_EN defined: on reaching terminal in RUN, the count is loaded from the stored reload value that edge. The FSM stays in RUN and done pulses once per wrap. DONE is never entered; only STOP or reset leaves RUN.
- Undefined: terminal behaviour is as in Behaviour (enter DONE).

Decomposition:
- Package jk_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - op encodings OP_NOP, OP_LOAD, OP_RUN, OP_STOP;
  - DIR_UP/DIR_DOWN constants.
- Sub-module jk_cell: one JK flip-flop with async active-high reset, inputs j, k, outputs q, q_bar.
  - Hold, reset, set and toggle on the rising edge.
  - Instantiated WIDTH times in a generate loop; the controller never writes count directly.

Test Plan:
- Reset: assert reset -> count=0, busy=0, done=0, cmd_err=0, cmd_ready=1.
- Basic up-count: LOAD 3, then RUN up term 7 -> count 4,5,6,7 on the next four edges. State DONE on the fifth edge, done high one cycle, busy falls.
- Wrap-around:
  - LOAD 14, RUN up term 1 -> 15,0,1 then done.
  - LOAD 2, RUN down term 14 -> 1,0,15,14 then done.
- STOP and error handling: LOAD 0, RUN up term 9; send STOP while count=3 -> count holds 3, IDLE, no done. Also send LOAD 5 during RUN -> cmd_err one cycle, counting continues.
- Reset and zero-length run:
  - Reset asserted asynchronously at count=5 mid-run -> count=0 and IDLE without waiting for a clock edge.
  - RUN with term=0 from count=0 -> done after one edge, zero steps.
- With JK_SEQ_AUTO_RELOAD_EN: LOAD 2, RUN up term 4 -> 3,4,2,3,4,2... with a done pulse at each reload. STOP -> IDLE, count held.
